// File: rtl/uart_packet_rx.sv
// UART receiver assembling BYTES_PER_WORD 8N1 bytes (LSB byte first) into one word.
// Optional even parity bit when UART_PARITY_EN is defined (8E1 framing).
module uart_packet_rx #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_BITS   = 20
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rx_i,
    output logic [7:0]                  byte_data_o,
    output logic                        byte_valid_o,
    output logic [8*BYTES_PER_WORD-1:0] word_data_o,
    output logic                        word_valid_o,
    output logic                        frame_err_o,
    output logic                        timeout_err_o,
    output logic                        busy_o
);

    localparam int unsigned WordW   = 8 * BYTES_PER_WORD;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToLimit = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned ToW     = $clog2(ToLimit + 1);
    localparam int unsigned IdxW    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(ToLimit - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitIdle} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;
`endif

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        byte_q, byte_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WordW-1:0]  word_q, word_d;
    logic [ToW-1:0]    to_q, to_d;
    logic              byte_valid_q, byte_valid_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!rx_q) state_d = StStart;
            StStart:    if (cnt_q == HalfCnt) state_d = rx_q ? StIdle : StData;
`ifdef UART_PARITY_EN
            StData:     if (cnt_q == FullCnt && bit_q == 3'd7) state_d = StParity;
            StParity: begin
                if (cnt_q == FullCnt) begin
                    if (rx_q == ^shift_q) state_d = StStop;
                    else                  state_d = rx_q ? StIdle : StWaitIdle;
                end
            end
`else
            StData:     if (cnt_q == FullCnt && bit_q == 3'd7) state_d = StStop;
`endif
            StStop:     if (cnt_q == FullCnt) state_d = rx_q ? StIdle : StWaitIdle;
            StWaitIdle: if (rx_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q + CntW'(1);
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        idx_d         = idx_q;
        word_d        = word_q;
        to_d          = '0;
        byte_valid_d  = 1'b0;
        word_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                // A start edge beats a timeout expiring in the same cycle.
                if (rx_q && idx_q != '0) begin
                    if (to_q == ToLast) begin
                        idx_d         = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        to_d = to_q + ToW'(1);
                    end
                end
            end
            StStart: if (cnt_q == HalfCnt) cnt_d = '0;
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (cnt_q == FullCnt) begin
                    cnt_d = '0;
                    if (rx_q != ^shift_q) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end
                end
            end
`endif
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d = '0;
                    if (rx_q) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                            if (idx_q == IdxW'(k)) word_d[8*k +: 8] = shift_q;
                        end
                        if (idx_q == LastIdx) begin
                            word_valid_d = 1'b1;
                            idx_d        = '0;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end
                end
            end
            StWaitIdle: cnt_d = '0;
            default:    cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q     <= 1'b1;
            rx_q          <= 1'b1;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            idx_q         <= '0;
            word_q        <= '0;
            to_q          <= '0;
            byte_valid_q  <= 1'b0;
            word_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_i;
            rx_q          <= rx_meta_q;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            idx_q         <= idx_d;
            word_q        <= word_d;
            to_q          <= to_d;
            byte_valid_q  <= byte_valid_d;
            word_valid_q  <= word_valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        byte_data_o   = byte_q;
        byte_valid_o  = byte_valid_q;
        word_data_o   = word_q;
        word_valid_o  = word_valid_q;
        frame_err_o   = frame_err_q;
        timeout_err_o = timeout_err_q;
        busy_o        = (state_q != StIdle) || (idx_q != '0);
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: scoreboard queues of expected bytes/words popped on pulses.
module tb_uart_packet_rx;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Bpw = 4;
    localparam int unsigned ToBits = 20;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_data_o;
    logic        byte_valid_o;
    logic [31:0] word_data_o;
    logic        word_valid_o;
    logic        frame_err_o;
    logic        timeout_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int n_byte = 0, n_word = 0, n_ferr = 0, n_terr = 0;
    int s_byte, s_word, s_ferr, s_terr;
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];

    uart_packet_rx #(
        .CLKS_PER_BIT  (Cpb),
        .BYTES_PER_WORD(Bpw),
        .TIMEOUT_BITS  (ToBits)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rx_i         (rx),
        .byte_data_o  (byte_data_o),
        .byte_valid_o (byte_valid_o),
        .word_data_o  (word_data_o),
        .word_valid_o (word_valid_o),
        .frame_err_o  (frame_err_o),
        .timeout_err_o(timeout_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int unsigned bits);
        rx = v;
        repeat (bits * Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        hold_rx(1'b0, 1);
        for (int i = 0; i < 8; i++) hold_rx(d[i], 1);
`ifdef UART_PARITY_EN
        hold_rx(par, 1);
`else
        if (par === 1'bx) hold_rx(1'b1, 0);
`endif
        hold_rx(stop, 1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_bytes.push_back(d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_words.push_back(w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic snap();
        s_byte = n_byte;
        s_word = n_word;
        s_ferr = n_ferr;
        s_terr = n_terr;
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (byte_valid_o) begin
                n_byte++;
                if (exp_bytes.size() == 0) check("unexpected_byte", 1, 0);
                else check("byte_data", byte_data_o, exp_bytes.pop_front());
            end
            if (word_valid_o) begin
                n_word++;
                if (exp_words.size() == 0) check("unexpected_word", 1, 0);
                else check("word_data", word_data_o, exp_words.pop_front());
            end
            if (frame_err_o) n_ferr++;
            if (timeout_err_o) n_terr++;
            if (byte_valid_o || frame_err_o || timeout_err_o)
                check("exclusive_pulse",
                      64'(byte_valid_o) + 64'(frame_err_o) + 64'(timeout_err_o), 1);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_byte_valid", byte_valid_o, 0);
        check("rst_word_valid", word_valid_o, 0);
        check("rst_word_data", word_data_o, 0);
        check("rst_byte_data", byte_data_o, 0);
        check("rst_errs", {frame_err_o, timeout_err_o}, 0);
        check("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        hold_rx(1'b1, 2);

        // 1: single packet, bytes 52 53 54 31
        snap();
        send_word(32'h3154_5352);
        hold_rx(1'b1, 2);
        check("t1_bytes", n_byte - s_byte, 4);
        check("t1_words", n_word - s_word, 1);
        check("t1_errs", (n_ferr - s_ferr) + (n_terr - s_terr), 0);

        // 2: back-to-back packets
        snap();
        send_word(32'h3030_3030);
        send_word(32'h3045_4D49);
        hold_rx(1'b1, 2);
        check("t2_words", n_word - s_word, 2);
        check("t2_errs", (n_ferr - s_ferr) + (n_terr - s_terr), 0);

        // 3: glitch shorter than half a bit
        snap();
        rx = 1'b0;
        repeat (Cpb / 4) @(negedge clk);
        hold_rx(1'b1, 2);
        check("t3_no_byte", n_byte - s_byte, 0);
        check("t3_busy", busy_o, 0);

        // 4: one good byte, then a framing error with the line held low
        snap();
        send_byte(8'hA5);
        send_frame(8'h3C, ^8'h3C, 1'b0);
        hold_rx(1'b0, 20);
        check("t4_frame_err", n_ferr - s_ferr, 1);
        check("t4_bytes", n_byte - s_byte, 1);
        check("t4_busy_low", busy_o, 1);
        hold_rx(1'b1, 2);
        check("t4_busy_idle", busy_o, 0);
        snap();
        send_word(32'h3145_4D49);
        hold_rx(1'b1, 2);
        check("t4_words", n_word - s_word, 1);

        // 5: partial word dropped by timeout
        snap();
        send_byte(8'h11);
        send_byte(8'h22);
        check("t5_busy_partial", busy_o, 1);
        hold_rx(1'b1, 25);
        check("t5_timeout", n_terr - s_terr, 1);
        check("t5_no_word", n_word - s_word, 0);
        check("t5_busy", busy_o, 0);
        snap();
        send_word(32'h3145_4D49);
        hold_rx(1'b1, 2);
        check("t5_words", n_word - s_word, 1);

        // 6: reset in the middle of byte 3
        send_byte(8'hA1);
        send_byte(8'hB2);
        hold_rx(1'b0, 1);
        hold_rx(1'b1, 1);
        hold_rx(1'b0, 1);
        hold_rx(1'b1, 1);
        rx = 1'b0;
        repeat (Cpb / 2) @(negedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("t6_rst_outputs",
              {byte_valid_o, word_valid_o, frame_err_o, timeout_err_o, busy_o}, 0);
        check("t6_rst_data", {word_data_o, byte_data_o}, 0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst_ni = 1'b1;
        hold_rx(1'b1, 2);
        snap();
        send_word(32'hDEAD_BEEF);
        hold_rx(1'b1, 2);
        check("t6_words", n_word - s_word, 1);
        check("t6_errs", (n_ferr - s_ferr) + (n_terr - s_terr), 0);

`ifdef UART_PARITY_EN
        // Even parity of 0x52 is 1; sending 0 must be rejected
        snap();
        send_frame(8'h52, 1'b0, 1'b1);
        hold_rx(1'b1, 2);
        check("par_frame_err", n_ferr - s_ferr, 1);
        check("par_no_byte", n_byte - s_byte, 0);
`endif

        check("bytes_left", exp_bytes.size(), 0);
        check("words_left", exp_words.size(), 0);
        check("total_words", n_word, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
